// File: rtl/dmem_access_unit_if.sv
// Request/response channel between the MEM stage (master) and the data-memory access unit (slave).
`timescale 1ns/1ps
interface dmem_access_unit_if;
    logic        req_valid_i;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        req_ready_o;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        err_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, err_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, err_o
    );
endinterface

// File: rtl/dmem_access_unit.sv
// Memory-stage load/store responder: decodes each request to data BRAM, MMIO (LED, switches,
// cycle counter) or an error, and answers with a one-cycle response pulse.
`timescale 1ns/1ps
module dmem_access_unit #(
    parameter int unsigned AW      = 12,
    parameter logic [31:0] IO_BASE = 32'hFFFF_F000,
    parameter int unsigned LED_W   = 16,
    parameter int unsigned SW_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    dmem_access_unit_if.slave bus,
    output logic             dram_en_o,
    output logic             dram_we_o,
    output logic [AW-1:0]    dram_addr_o,
    output logic [31:0]      dram_wdata_o,
    input  logic [31:0]      dram_rdata_i,
    output logic [LED_W-1:0] led_o,
    input  logic [SW_W-1:0]  sw_i
);

    typedef enum logic [0:0] {StIdle, StRdWait} state_e;

    state_e             r_state;
    logic               r_rsp_valid;
    logic               r_err;
    logic [31:0]        r_rsp_rdata;
    logic [LED_W-1:0]   r_led;
    logic [31:0]        r_cycle;
    logic [SW_W-1:0]    r_sw_meta;
    logic [SW_W-1:0]    r_sw_sync;

    logic               w_accept;
    logic               w_misaligned;
    logic               w_dram_sel;
    logic               w_mmio_sel;
    logic               w_dram_hit;
    logic               w_mmio_hit;
    logic [9:0]         w_offset;
    logic [31:0]        w_mmio_rdata;

    // Gating with reset keeps the BRAM strobes low the instant reset asserts.
    assign w_accept     = rst_n_i & bus.req_valid_i & (r_state == StIdle);
    assign w_misaligned = |bus.req_addr_i[1:0];
    assign w_dram_sel   = (bus.req_addr_i[31:AW+2] == '0);
    assign w_mmio_sel   = (bus.req_addr_i[31:12] == IO_BASE[31:12]);
    assign w_dram_hit   = !w_misaligned & w_dram_sel;
    assign w_mmio_hit   = !w_misaligned & !w_dram_sel & w_mmio_sel;
    assign w_offset     = bus.req_addr_i[11:2];

    assign bus.req_ready_o = (r_state == StIdle);
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_rdata_o = r_rsp_rdata;
    assign bus.err_o       = r_err;

    assign dram_en_o    = w_accept & w_dram_hit;
    assign dram_we_o    = w_accept & w_dram_hit & bus.req_we_i;
    assign dram_addr_o  = bus.req_addr_i[AW+1:2];
    assign dram_wdata_o = bus.req_wdata_i;
    assign led_o        = r_led;

    always_comb begin
        w_mmio_rdata = '0;
        case (w_offset)
            10'd0:   w_mmio_rdata = 32'(r_led);
            10'd1:   w_mmio_rdata = 32'(r_sw_sync);
            10'd2:   w_mmio_rdata = r_cycle;
            default: w_mmio_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= StIdle;
            r_rsp_valid <= 1'b0;
            r_err       <= 1'b0;
            r_rsp_rdata <= '0;
            r_led       <= '0;
            r_cycle     <= '0;
            r_sw_meta   <= '0;
            r_sw_sync   <= '0;
        end else begin
            r_sw_meta   <= sw_i;
            r_sw_sync   <= r_sw_meta;
            r_rsp_valid <= 1'b0;
            r_err       <= 1'b0;
            // A counter write below overrides this increment.
            r_cycle     <= r_cycle + 32'd1;

            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        if (w_dram_hit) begin
                            if (bus.req_we_i) begin
                                r_rsp_valid <= 1'b1;
                                r_rsp_rdata <= '0;
                            end else begin
                                r_state <= StRdWait;
                            end
                        end else if (w_mmio_hit) begin
                            r_rsp_valid <= 1'b1;
                            if (bus.req_we_i) begin
                                r_rsp_rdata <= '0;
                                if (w_offset == 10'd0) r_led   <= bus.req_wdata_i[LED_W-1:0];
                                if (w_offset == 10'd2) r_cycle <= bus.req_wdata_i;
                            end else begin
                                r_rsp_rdata <= w_mmio_rdata;
                            end
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_err       <= 1'b1;
                            r_rsp_rdata <= '0;
                        end
                    end
                end
                StRdWait: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= dram_rdata_i;
                    r_state     <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed and randomized bench for dmem_access_unit with a behavioural memory/MMIO model.
`timescale 1ns/1ps
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dram_en;
    logic        dram_we;
    logic [11:0] dram_addr;
    logic [31:0] dram_wdata;
    bit   [31:0] bram_q;
    logic [15:0] led;
    logic [15:0] sw = '0;

    bit   [31:0] bram [4096];

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state, expressed as plain values and timestamps.
    bit   [31:0] ref_mem [int];
    logic [15:0] ref_led;
    longint      cyc_base_t;
    logic [31:0] cyc_base_v;
    logic [15:0] sw_old;
    logic [15:0] sw_new;
    longint      sw_edge;
    logic [31:0] last_rdata;

    dmem_access_unit_if bus();

    dmem_access_unit dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .bus          (bus),
        .dram_en_o    (dram_en),
        .dram_we_o    (dram_we),
        .dram_addr_o  (dram_addr),
        .dram_wdata_o (dram_wdata),
        .dram_rdata_i (bram_q),
        .led_o        (led),
        .sw_i         (sw)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dram_en) begin
            if (dram_we) bram[dram_addr] <= dram_wdata;
            bram_q <= bram[dram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Counter value seen just before an edge at time t.
    function automatic logic [31:0] cyc_at(input longint t);
        return cyc_base_v + 32'((t - cyc_base_t) / 10) - 32'd1;
    endfunction

    // Called at a negedge right after rst_n rises.
    task automatic rebase_after_reset();
        cyc_base_t = $time - 5;
        cyc_base_v = '0;
        ref_led    = '0;
        sw_old     = '0;
        sw_new     = sw;
        sw_edge    = $time + 5;
    endtask

    task automatic set_sw(input logic [15:0] val);
        @(negedge clk);
        sw_old  = sw_new;
        sw_new  = val;
        sw      = val;
        sw_edge = $time + 5;
    endtask

    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] exp_d;
        logic        exp_err;
        logic        is_dram;
        logic        is_mmio;
        int          lat;
        longint      tacc;
        int          off;
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = we;
        bus.req_addr_i  = addr;
        bus.req_wdata_i = wdata;
        #1;
        tacc    = $time + 4;
        is_dram = (addr % 4 == 0) && (addr < 32'h0000_4000);
        is_mmio = (addr % 4 == 0) && !is_dram && (addr >= 32'hFFFF_F000);
        exp_err = !is_dram && !is_mmio;
        exp_d   = '0;
        lat     = 1;
        check("ready_idle", 32'(bus.req_ready_o), 32'd1);
        check("dram_en", 32'(dram_en), 32'(is_dram));
        check("dram_we", 32'(dram_we), 32'(is_dram && we));
        if (is_dram) check("dram_addr", 32'(dram_addr), addr / 4);
        if (is_dram) begin
            if (we) ref_mem[int'(addr / 4)] = wdata;
            else begin
                exp_d = ref_mem.exists(int'(addr / 4)) ? ref_mem[int'(addr / 4)] : 32'd0;
                lat   = 2;
            end
        end else if (is_mmio) begin
            off = int'((addr - 32'hFFFF_F000) / 4);
            if (off == 0) begin
                if (we) ref_led = wdata[15:0];
                else exp_d = {16'd0, ref_led};
            end else if (off == 1) begin
                if (!we) exp_d = {16'd0, (tacc >= sw_edge + 20) ? sw_new : sw_old};
            end else if (off == 2) begin
                if (we) begin
                    cyc_base_t = tacc;
                    cyc_base_v = wdata;
                end else exp_d = cyc_at(tacc);
            end
        end
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        if (lat == 2) begin
            check("ready_rdwait", 32'(bus.req_ready_o), 32'd0);
            check("rsp_early", 32'(bus.rsp_valid_o), 32'd0);
            @(posedge clk);
            #1;
        end
        check("rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
        check("rsp_err", 32'(bus.err_o), 32'(exp_err));
        check("rsp_rdata", bus.rsp_rdata_o, exp_d);
        check("led", 32'(led), 32'(ref_led));
        last_rdata = bus.rsp_rdata_o;
        @(posedge clk);
        #1;
        check("rsp_pulse", 32'(bus.rsp_valid_o), 32'd0);
        check("err_pulse", 32'(bus.err_o), 32'd0);
        check("rdata_hold", bus.rsp_rdata_o, exp_d);
        check("dram_en_idle", 32'(dram_en), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        int          k;
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = 1'b1;
        bus.req_addr_i  = 32'h0000_0010;
        bus.req_wdata_i = '0;
        #1;
        check("rst_dram_en", 32'(dram_en), 32'd0);
        check("rst_dram_we", 32'(dram_we), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        check("rst_rdata", bus.rsp_rdata_o, 32'd0);
        check("rst_err", 32'(bus.err_o), 32'd0);
        check("rst_led", 32'(led), 32'd0);
        check("rst_ready", 32'(bus.req_ready_o), 32'd1);
        bus.req_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rebase_after_reset();

        // DRAM round trip
        txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        txn(1'b0, 32'h0000_0010, 32'h0);
        check("dram_roundtrip", last_rdata, 32'hDEAD_BEEF);

        // LED write/read
        txn(1'b1, 32'hFFFF_F000, 32'h1234_A5A5);
        txn(1'b0, 32'hFFFF_F000, 32'h0);
        check("led_read", last_rdata, 32'h0000_A5A5);

        // Switch synchroniser: early read sees old value, later read sees new
        set_sw(16'h1234);
        txn(1'b0, 32'hFFFF_F004, 32'h0);
        check("sw_early", last_rdata, 32'h0000_0000);
        txn(1'b0, 32'hFFFF_F004, 32'h0);
        check("sw_late", last_rdata, 32'h0000_1234);
        txn(1'b1, 32'hFFFF_F004, 32'hFFFF_FFFF);

        // Errors
        txn(1'b0, 32'h0000_0011, 32'h0);
        txn(1'b1, 32'h8000_0000, 32'h5555_5555);

        // Counter wrap: load accepted four edges after the write
        txn(1'b1, 32'hFFFF_F008, 32'hFFFF_FFFE);
        repeat (2) @(negedge clk);
        txn(1'b0, 32'hFFFF_F008, 32'h0);
        check("cycle_wrap", last_rdata, 32'h0000_0001);

        // Unmapped MMIO offsets
        txn(1'b1, 32'hFFFF_F00C, 32'hCAFE_F00D);
        txn(1'b0, 32'hFFFF_FFFC, 32'h0);

        // Back-to-back: LED store then LED load accepted while the store response is shown
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = 1'b1;
        bus.req_addr_i  = 32'hFFFF_F000;
        bus.req_wdata_i = 32'h0000_5A5A;
        @(posedge clk);
        #1;
        ref_led         = 16'h5A5A;
        bus.req_we_i    = 1'b0;
        check("b2b_rsp1", 32'(bus.rsp_valid_o), 32'd1);
        check("b2b_ready", 32'(bus.req_ready_o), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        check("b2b_rsp2", 32'(bus.rsp_valid_o), 32'd1);
        check("b2b_rdata", bus.rsp_rdata_o, 32'h0000_5A5A);
        @(posedge clk);
        #1;
        check("b2b_pulse", 32'(bus.rsp_valid_o), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            k = int'($urandom_range(0, 9));
            if ($urandom_range(0, 15) == 0) set_sw(16'($urandom));
            case (k)
                0, 1, 2: a = 32'($urandom_range(0, 63)) * 4;
                3:       a = 32'h0000_3FFC;
                4, 5:    a = 32'hFFFF_F000 + 32'($urandom_range(0, 3)) * 4;
                6:       a = 32'hFFFF_F000 + 32'($urandom_range(4, 1023)) * 4;
                7:       a = (32'($urandom_range(0, 63)) * 4) | 32'($urandom_range(1, 3));
                8:       a = (32'h0000_4000 + 32'($urandom_range(0, 32'h7FFF_0000))) & ~32'd3;
                default: a = 32'hFFFF_E000 + 32'($urandom_range(0, 1023)) * 4;
            endcase
            txn(1'($urandom_range(0, 1)), a, $urandom);
        end

        // Reset during RD_WAIT drops the load
        txn(1'b1, 32'hFFFF_F000, 32'h0000_00FF);
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = 1'b0;
        bus.req_addr_i  = 32'h0000_0010;
        @(posedge clk);
        #1;
        check("rdwait_ready", 32'(bus.req_ready_o), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_dram_en", 32'(dram_en), 32'd0);
        check("mid_rst_ready", 32'(bus.req_ready_o), 32'd1);
        check("mid_rst_led", 32'(led), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_no_rsp", 32'(bus.rsp_valid_o), 32'd0);
        end
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rebase_after_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_no_rsp", 32'(bus.rsp_valid_o), 32'd0);
            check("post_rst_ready", 32'(bus.req_ready_o), 32'd1);
        end
        txn(1'b0, 32'hFFFF_F008, 32'h0);
        txn(1'b0, 32'h0000_0010, 32'h0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
